// File: rtl/sparse_match_multilane.sv
// rtl/sparse_match_multilane.sv - multi-lane sparse fibre intersection extractor
// Optional SPARSE_MATCH_STATS_EN adds match/stall statistics counters.
module sparse_match_multilane #(
    parameter int BITMASK_WIDTH = 128,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int LANES         = 2,
    localparam int PW           = $clog2(BITMASK_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BITMASK_WIDTH-1:0]          bitmask_a,
    input  logic [BITMASK_WIDTH-1:0]          bitmask_b,
    input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] fibre_a_data_flat,
    input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] fibre_b_data_flat,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES-1:0]                  out_lane_valid,
    output logic [LANES*PW-1:0]               out_position,
    output logic [LANES*PW-1:0]               out_offset_a,
    output logic [LANES*PW-1:0]               out_offset_b,
    output logic [LANES*WEIGHT_WIDTH-1:0]     out_weight_a,
    output logic [LANES*WEIGHT_WIDTH-1:0]     out_weight_b,
    output logic                              out_last,
    output logic [PW:0]                       match_count,
`ifdef SPARSE_MATCH_STATS_EN
    output logic [31:0]                       stat_match_total,
    output logic [31:0]                       stat_stall_cycles,
`endif
    output logic                              busy
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                              state;
    logic [BITMASK_WIDTH-1:0]            mask_a_q, mask_b_q, residual;
    logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] data_a_q, data_b_q;

    logic [LANES-1:0]                    nxt_lane_valid;
    logic [LANES*PW-1:0]                 nxt_position, nxt_offset_a, nxt_offset_b;
    logic [LANES*WEIGHT_WIDTH-1:0]       nxt_weight_a, nxt_weight_b;
    logic [BITMASK_WIDTH-1:0]            nxt_residual, scan;
    logic                                found;
    logic [PW-1:0]                       pos, off_a, off_b;

    // Ones strictly below pos; never exceeds BITMASK_WIDTH-1 so PW bits suffice.
    function automatic logic [PW-1:0] ones_below(input logic [BITMASK_WIDTH-1:0] m,
                                                 input logic [PW-1:0] p);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BITMASK_WIDTH; i++)
            if (PW'(i) < p) cnt = cnt + PW'(m[i]);
        return cnt;
    endfunction

    function automatic logic [PW:0] popcount(input logic [BITMASK_WIDTH-1:0] m);
        logic [PW:0] cnt;
        cnt = '0;
        for (int i = 0; i < BITMASK_WIDTH; i++) cnt = cnt + (PW+1)'(m[i]);
        return cnt;
    endfunction

    always_comb begin
        nxt_lane_valid = '0;
        nxt_position   = '0;
        nxt_offset_a   = '0;
        nxt_offset_b   = '0;
        nxt_weight_a   = '0;
        nxt_weight_b   = '0;
        scan           = residual;
        found          = 1'b0;
        pos            = '0;
        off_a          = '0;
        off_b          = '0;
        for (int l = 0; l < LANES; l++) begin
            found = 1'b0;
            pos   = '0;
            for (int i = 0; i < BITMASK_WIDTH; i++) begin
                if (!found && scan[i]) begin
                    found = 1'b1;
                    pos   = PW'(i);
                end
            end
            if (found) begin
                scan[pos]                               = 1'b0;
                off_a                                   = ones_below(mask_a_q, pos);
                off_b                                   = ones_below(mask_b_q, pos);
                nxt_lane_valid[l]                       = 1'b1;
                nxt_position[l*PW +: PW]                = pos;
                nxt_offset_a[l*PW +: PW]                = off_a;
                nxt_offset_b[l*PW +: PW]                = off_b;
                nxt_weight_a[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                    data_a_q[int'(off_a)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                nxt_weight_b[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                    data_b_q[int'(off_b)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        nxt_residual = scan;
    end

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state == EMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mask_a_q       <= '0;
            mask_b_q       <= '0;
            data_a_q       <= '0;
            data_b_q       <= '0;
            residual       <= '0;
            match_count    <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_lane_valid <= '0;
            out_position   <= '0;
            out_offset_a   <= '0;
            out_offset_b   <= '0;
            out_weight_a   <= '0;
            out_weight_b   <= '0;
        end else if (flush) begin
            state          <= IDLE;
            residual       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_lane_valid <= '0;
            out_position   <= '0;
            out_offset_a   <= '0;
            out_offset_b   <= '0;
            out_weight_a   <= '0;
            out_weight_b   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The final beat of the previous fibre may still be held here.
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (in_valid) begin
                        mask_a_q    <= bitmask_a;
                        mask_b_q    <= bitmask_b;
                        data_a_q    <= fibre_a_data_flat;
                        data_b_q    <= fibre_b_data_flat;
                        residual    <= bitmask_a & bitmask_b;
                        match_count <= popcount(bitmask_a & bitmask_b);
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    if (!out_valid || out_ready) begin
                        out_valid      <= 1'b1;
                        out_lane_valid <= nxt_lane_valid;
                        out_position   <= nxt_position;
                        out_offset_a   <= nxt_offset_a;
                        out_offset_b   <= nxt_offset_b;
                        out_weight_a   <= nxt_weight_a;
                        out_weight_b   <= nxt_weight_b;
                        residual       <= nxt_residual;
                        out_last       <= (nxt_residual == '0);
                        if (nxt_residual == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPARSE_MATCH_STATS_EN
    logic [31:0] beat_matches;

    always_comb begin
        beat_matches = '0;
        for (int l = 0; l < LANES; l++) beat_matches = beat_matches + 32'(out_lane_valid[l]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_match_total  <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (out_valid && out_ready) begin
                if (stat_match_total > (32'hFFFF_FFFF - beat_matches))
                    stat_match_total <= 32'hFFFF_FFFF;
                else
                    stat_match_total <= stat_match_total + beat_matches;
            end
            if (out_valid && !out_ready && stat_stall_cycles != 32'hFFFF_FFFF)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/sparse_match_multilane.md
Name: sparse_match_multilane

Overview:
- Next-generation sparse-intersection match extractor for the tensor-processing PE datapath.
- Takes one fibre pair per transaction: bitmasks A and B, plus compressed weight arrays A and B. Emits up to LANES intersecting positions per beat over a valid/ready stream.
- Each lane carries the position, the compressed offsets into both fibres, and both weights, so the downstream MAC gets operand pairs directly.
- Replaces the one-match-per-three-cycles scanner. Supports backpressure, empty-fibre signalling and flush.

Parameters:
BITMASK_WIDTH, 128, bits per fibre bitmask; power of two, >=4
WEIGHT_WIDTH, 8, bits per weight
LANES, 2, max matches emitted per beat; 1..8
(PW = $clog2(BITMASK_WIDTH), derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of current fibre
in_valid  in  1  fibre pair offered
in_ready  out  1  block can accept fibre pair
bitmask_a  in  BITMASK_WIDTH  fibre A occupancy
bitmask_b  in  BITMASK_WIDTH  fibre B occupancy
fibre_a_data_flat  in  BITMASK_WIDTH*WEIGHT_WIDTH  compressed A weights; entry i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
fibre_b_data_flat  in  BITMASK_WIDTH*WEIGHT_WIDTH  compressed B weights, same packing
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat
out_lane_valid  out  LANES  per-lane valid, thermometer from lane 0
out_position  out  LANES*PW  matched bit position per lane
out_offset_a  out  LANES*PW  ones in bitmask_a below position
out_offset_b  out  LANES*PW  ones in bitmask_b below position
out_weight_a  out  LANES*WEIGHT_WIDTH  fibre_a_data[offset_a]
out_weight_b  out  LANES*WEIGHT_WIDTH  fibre_b_data[offset_b]
out_last  out  1  final beat of current fibre
match_count  out  PW+1  popcount(bitmask_a & bitmask_b) of the fibre currently in EMIT
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - All out_* outputs, match_count and busy are 0.
  - in_ready=1 after reset release.
- States:
  - IDLE:
    - in_ready = !flush.
    - On in_valid && in_ready: register both masks, both data arrays, residual = bitmask_a & bitmask_b, and match_count; go to EMIT.
    - Note: in_ready depends on flush only, not on out_ready.
  - EMIT:
    - in_ready=0.
    - Each cycle the output register is free (!out_valid || out_ready), load a beat.
    - Beat contents: the LANES lowest set bits of residual, ascending, lane 0 = lowest. Those bits are then cleared from residual.
    - If residual is empty after loading, set out_last=1 and return to IDLE.
    - First-beat exception: if residual==0 on entry, emit one beat with out_lane_valid=0 and out_last=1.
- Latency and throughput:
  - Accept at edge E0 → first beat registered at E1; out_valid high from E1.
  - Steady throughput is one beat per cycle with out_ready held high.
  - A fibre with n matches takes max(1, ceil(n/LANES)) beats.
  - The next fibre can be accepted in the cycle after the last beat loads (IDLE overlaps the held last beat). Its first beat loads only once the held beat is consumed.
- Handshake:
  - A beat transfers on out_valid && out_ready.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - out_valid drops after a transfer when no new beat is loaded.
  - in_valid may drop without acceptance; no state change.
- Unused lanes: position, offsets and weights are 0 and lane_valid is 0.
- Arithmetic:
  - Offsets are popcounts strictly below the position, so 0..BITMASK_WIDTH-1 fits PW bits.
  - Weight index equals the offset; no range error is possible.
- flush (synchronous, any state):
  - Next edge: state=IDLE, residual cleared, out_valid=0, out_last=0, out_lane_valid=0.
  - The pending beat is dropped.
  - flush has priority over in_valid and over out_ready.
- Reset mid-EMIT: immediate return to reset values; the fibre is lost.

Optional Feature:
- Macro: SPARSE_MATCH_STATS_EN.
- When defined, two ports are added:
  - stat_match_total, out, 32: saturating count of lane-valid lanes in transferred beats.
  - stat_stall_cycles, out, 32: saturating count of cycles with out_valid && !out_ready.
- Both counters reset to 0 on rst_n only. flush does not clear them.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- W=16, LANES=2, a=0x00F0, b=0x0130, out_ready=1:
  - one beat, lane_valid=2'b11, positions {4,5}, offset_a {0,1}, offset_b {0,1}, out_last=1, match_count=2.
  - first beat registered at E1 after accept.
- a=0xFFFF, b=0x8001, fibre_b_data[1]=0x5A:
  - one beat, positions {0,15}, offset_a {0,15}, offset_b {0,1}.
  - lane1 weight_b=0x5A.
- a=b=0x0007: two beats.
  - beat1: positions {0,1}, last=0.
  - beat2: lane_valid=2'b01, position 2, last=1.
  - in_ready re-asserts the cycle after beat2 loads.
- a=0x000F, b=0x00F0 (empty intersection):
  - one beat, lane_valid=0, out_last=1, match_count=0.
- Backpressure on a=b=0x00FF: drop out_ready for 3 cycles mid-fibre.
  - outputs stable throughout; all 8 positions delivered in order, exactly once, over 4 beats.
  - with SPARSE_MATCH_STATS_EN: stat_stall_cycles=3, stat_match_total=8.
- Corner events:
  - flush asserted with in_valid high during EMIT: next cycle out_valid=0, busy=0, new fibre not accepted that cycle.
  - rst_n pulse mid-EMIT: all outputs 0 asynchronously.
